// File: rtl/rv32m_ext_unit.sv
// External RV32M multiply/divide responder: iterative shift-add multiply and
// restoring divide behind a start-pulse / one-cycle-acknowledge handshake.
module rv32m_ext_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_en,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [2:0]      i_f3,
  output logic [XLEN-1:0] o_res,
  output logic            o_ack,
  output logic            o_busy
);

  localparam int unsigned CW = $clog2(XLEN) + 1;
  localparam int unsigned AW = 2 * XLEN;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_MUL     = 3'd1;
  localparam logic [2:0] S_DIV     = 3'd2;
  localparam logic [2:0] S_FIX     = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam logic [2:0] S_SPECIAL = 3'd5;

  logic [2:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   acc_q, acc_d;     // mul: {hi, lo/multiplier}; div: {rem, quo}
  logic [XLEN-1:0] op_q, op_d;       // multiplicand or divisor magnitude
  logic [2:0]      f3_q, f3_d;
  logic            sa_q, sa_d, sb_q, sb_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            ack_q, ack_d, busy_q, busy_d;

  // Operand-capture helpers (combinational from the inputs)
  logic            sa_in, sb_in, spec_zero, spec_ovf;
  logic [XLEN-1:0] a_mag, b_mag, spec_res;

  assign sa_in = i_rs1[XLEN-1] & ((i_f3[2] & ~i_f3[0]) |
                 (~i_f3[2] & (i_f3[1:0] == 2'b01 || i_f3[1:0] == 2'b10)));
  assign sb_in = i_rs2[XLEN-1] & ((i_f3[2] & ~i_f3[0]) |
                 (~i_f3[2] & (i_f3[1:0] == 2'b01)));
  assign a_mag = sa_in ? -i_rs1 : i_rs1;
  assign b_mag = sb_in ? -i_rs2 : i_rs2;

  assign spec_zero = (i_rs2 == '0);
  assign spec_ovf  = ~i_f3[0] & (i_rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (i_rs2 == '1);
  assign spec_res  = spec_zero ? (i_f3[1] ? i_rs1 : '1) : (i_f3[1] ? '0 : i_rs1);

  // Iteration datapath
  logic [XLEN:0]   mul_sum, div_shift, div_diff;
  assign mul_sum   = {1'b0, acc_q[AW-1:XLEN]} + {1'b0, op_q};
  assign div_shift = {acc_q[AW-1:XLEN], acc_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, op_q};

  // Sign fix-up of the finished magnitudes
  logic            neg;
  logic [AW-1:0]   prod;
  logic [XLEN-1:0] quo, rem, fix_res;
  assign neg  = sa_q ^ sb_q;
  assign prod = neg ? -acc_q : acc_q;
  assign quo  = neg ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem  = sa_q ? -acc_q[AW-1:XLEN] : acc_q[AW-1:XLEN];
  assign fix_res = !f3_q[2] ? ((f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[AW-1:XLEN])
                            : (f3_q[1] ? rem : quo);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    op_d    = op_q;
    f3_d    = f3_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    ack_d   = ack_q;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: begin
        if (i_en) begin
          f3_d   = i_f3;
          sa_d   = sa_in;
          sb_d   = sb_in;
          cnt_d  = '0;
          busy_d = 1'b1;
          if (!i_f3[2]) begin
            acc_d   = {{XLEN{1'b0}}, b_mag};
            op_d    = a_mag;
            state_d = S_MUL;
          end else if (spec_zero || spec_ovf) begin
            acc_d   = {{XLEN{1'b0}}, spec_res};
            op_d    = '0;
            state_d = S_SPECIAL;
          end else begin
            acc_d   = {{XLEN{1'b0}}, a_mag};
            op_d    = b_mag;
            state_d = S_DIV;
          end
        end
      end
      S_MUL: begin
        acc_d = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[AW-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(XLEN - 1)) state_d = S_FIX;
      end
      S_DIV: begin
        if (!div_diff[XLEN]) acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        else                 acc_d = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(XLEN - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        res_d   = fix_res;
        ack_d   = 1'b1;
        state_d = S_DONE;
      end
      S_SPECIAL: begin
        res_d   = acc_q[XLEN-1:0];
        ack_d   = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        ack_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      op_q    <= '0;
      f3_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      res_q   <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      f3_q    <= f3_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign o_res  = res_q;
  assign o_ack  = ack_q;
  assign o_busy = busy_q;

endmodule

// File: tb/tb_rv32m_ext_unit.sv
// Bench for rv32m_ext_unit: directed vector table, corner sequences, and
// randomized operations checked against an arithmetic reference model.
module tb_rv32m_ext_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic [31:0] rs1 = '0, rs2 = '0;
  logic [2:0]  f3  = '0;
  logic [31:0] res;
  logic        ack, busy;

  int n_vec = 0;
  int n_mis = 0;

  rv32m_ext_unit #(.XLEN(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_rs1(rs1), .i_rs2(rs2), .i_f3(f3),
    .o_res(res), .o_ack(ack), .o_busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference results straight from the RV32M definitions
  function automatic logic [31:0] ref_res(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] f);
    longint      sa, sb, ub, p;
    logic [63:0] up;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
    if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 33;
  endfunction

  // One full transaction: start, latency, result, ack width, busy release
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                        input logic [31:0] exp, input int exp_lat, input string name);
    int lat;
    @(negedge clk);
    en = 1'b1; rs1 = a; rs2 = b; f3 = f;
    @(posedge clk); #1;
    en = 1'b0; rs1 = $urandom; rs2 = $urandom; f3 = 3'($urandom);
    chk({name, "_busy"}, 32'(busy), 32'd1);
    lat = 0;
    while (!ack && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({name, "_res"}, res, exp);
    @(posedge clk); #1;
    chk({name, "_ackw"}, 32'(ack), 32'd0);
    chk({name, "_idle"}, 32'(busy), 32'd0);
    chk({name, "_hold"}, res, exp);
  endtask

  vec_t vt[14];

  initial begin
    int ack_seen, busy_bad, ack_edge;
    logic [31:0] a, b;
    logic [2:0]  f;

    vt[0]  = '{32'd7,          32'hFFFF_FFFD, 3'd0, 32'hFFFF_FFEB};
    vt[1]  = '{32'h8000_0000,  32'h8000_0000, 3'd1, 32'h4000_0000};
    vt[2]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF, 3'd3, 32'hFFFF_FFFE};
    vt[3]  = '{32'hFFFF_FFFF,  32'd2,         3'd2, 32'hFFFF_FFFF};
    vt[4]  = '{32'd100,        32'd7,         3'd5, 32'd14};
    vt[5]  = '{32'd100,        32'd7,         3'd7, 32'd2};
    vt[6]  = '{32'hFFFF_FFF9,  32'd2,         3'd4, 32'hFFFF_FFFD};
    vt[7]  = '{32'hFFFF_FFF9,  32'd2,         3'd6, 32'hFFFF_FFFF};
    vt[8]  = '{32'd5,          32'd0,         3'd4, 32'hFFFF_FFFF};
    vt[9]  = '{32'd5,          32'd0,         3'd7, 32'd5};
    vt[10] = '{32'h8000_0000,  32'hFFFF_FFFF, 3'd4, 32'h8000_0000};
    vt[11] = '{32'h8000_0000,  32'hFFFF_FFFF, 3'd6, 32'd0};
    vt[12] = '{32'h8000_0000,  32'hFFFF_FFFF, 3'd5, 32'd0};
    vt[13] = '{32'h8000_0000,  32'hFFFF_FFFF, 3'd7, 32'h8000_0000};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_res", res, 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk); rst = 1'b1;

    foreach (vt[i])
      run_op(vt[i].a, vt[i].b, vt[i].f, vt[i].exp, ref_lat(vt[i].a, vt[i].b, vt[i].f),
             $sformatf("vec%0d", i));

    // Reset at edge 10 of a running multiply aborts it
    @(negedge clk);
    en = 1'b1; rs1 = 32'd123; rs2 = 32'd456; f3 = 3'd0;
    @(posedge clk); #1; en = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_res", res, 32'd0);
    chk("abort_ack", 32'(ack), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    @(negedge clk); rst = 1'b1;
    ack_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ack || busy) ack_seen++;
    end
    chk("abort_noack", 32'(ack_seen), 32'd0);
    run_op(32'd9, 32'd3, 3'd5, 32'd3, 33, "post_rst");

    // Start pulses at edges 5, 33 and during DONE are all ignored
    @(negedge clk);
    en = 1'b1; rs1 = 32'd7; rs2 = 32'hFFFF_FFFD; f3 = 3'd0;
    @(posedge clk); #1; en = 1'b0;
    busy_bad = 0; ack_edge = -1;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      en = (k == 5 || k == 33 || k == 34);
      rs1 = 32'd3; rs2 = 32'd5; f3 = 3'd5;
      @(posedge clk); #1;
      en = 1'b0;
      if (k <= 33 && !busy) busy_bad++;
      if (ack && ack_edge < 0) ack_edge = k;
    end
    chk("ign_busy", 32'(busy_bad), 32'd0);
    chk("ign_lat", 32'(ack_edge), 32'd33);
    chk("ign_res", res, 32'hFFFF_FFEB);
    chk("ign_busy_off", 32'(busy), 32'd0);
    chk("ign_ack_off", 32'(ack), 32'd0);
    @(posedge clk); #1;
    chk("ign_still_idle", 32'(busy), 32'd0);

    // Randomized operations with biased corner operands
    for (int n = 0; n < 150; n++) begin
      a = $urandom; b = $urandom; f = 3'($urandom);
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: a = 32'hFFFF_FFFF;
        3: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op(a, b, f, ref_res(a, b, f), ref_lat(a, b, f), $sformatf("rnd%0d_f%0d", n, f));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
